dma_io_device: RTL and testbench

//  Peripheral-side responder for one channel of the DMA controller's DREQ/DACK handshake.
//  - Raises DREQ when its 4-deep data FIFO can complete one single-mode transfer.
//  - Answers the controller's DACK and IOR_N/IOW_N strobes, and drives or captures the data bus.
//  - Latches terminal count when EOP_N is sampled low.
//  - Host side is a valid/ready stream into or out of the FIFO.
//  - Used as the bus-functional peripheral in system benches.
//  - Single clock domain; all bus inputs are sampled on CLK, with no synchronizers.

---
 rtl/dma_io_device.sv | 163 ++++++++++++++++
 tb/tb_dma_io_device.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_io_device.sv
// Peripheral-side DREQ/DACK responder for one DMA channel, with a small FIFO
// between the controller data bus and a host valid/ready stream.
module dma_io_device #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EN,
  input  logic              DIR,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic              HIN_VALID,
  input  logic [DATA_W-1:0] HIN_DATA,
  output logic              HIN_READY,
  output logic              HOUT_VALID,
  output logic [DATA_W-1:0] HOUT_DATA,
  input  logic              HOUT_READY,
  output logic              TC,
  input  logic              TC_CLR
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_XFER,
    S_RECOVER
  } state_e;

  state_e            state_q;
  logic              dreq_q;
  logic              db_oe_q;
  logic              tc_q;
  logic              dir_q;
  logic [DATA_W-1:0] db_out_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              full_c;
  logic              empty_c;
  logic              strobe_low_c;
  logic              xfer_done_c;
  logic              host_push_c;
  logic              host_pop_c;
  logic              dma_push_c;
  logic              dma_pop_c;
  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] push_data_c;
  logic [DATA_W-1:0] head_c;

  assign full_c       = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_c      = (cnt_q == '0);
  assign head_c       = mem_q[rptr_q];
  assign strobe_low_c = dir_q ? !IOR_N : !IOW_N;

  // A transfer ends on the strobe rising or on DACK being withdrawn mid-strobe.
  assign xfer_done_c  = (state_q == S_XFER) && (!strobe_low_c || !DACK);
  assign dma_pop_c    = xfer_done_c && dir_q;
  assign dma_push_c   = xfer_done_c && !dir_q;
  assign host_push_c  = HIN_VALID && HIN_READY;
  assign host_pop_c   = HOUT_VALID && HOUT_READY;
  assign push_c       = (host_push_c || dma_push_c) && !full_c;
  assign pop_c        = (host_pop_c || dma_pop_c) && !empty_c;
  assign push_data_c  = dma_push_c ? (strobe_low_c ? DB_IN : cap_q) : HIN_DATA;

  assign DREQ       = dreq_q;
  assign DB_OE      = db_oe_q;
  assign DB_OUT     = db_out_q;
  assign TC         = tc_q;
  assign HIN_READY  = dir_q && !full_c;
  assign HOUT_VALID = !dir_q && !empty_c;
  assign HOUT_DATA  = head_c;

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_c)  rptr_q <= rptr_q + PTR_W'(1);
      if (push_c && !pop_c)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop_c && !push_c) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wptr_q] <= push_data_c;
  end

  // Handshake FSM with registered bus outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      dreq_q   <= 1'b0;
      db_oe_q  <= 1'b0;
      db_out_q <= '0;
      cap_q    <= '0;
      tc_q     <= 1'b0;
      dir_q    <= 1'b1;
    end else begin
      if (!EOP_N && (state_q inside {S_ACK, S_XFER, S_RECOVER})) tc_q <= 1'b1;
      else if (TC_CLR)                                           tc_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          dir_q <= DIR;
          if (EN && !tc_q && (DIR ? !empty_c : !full_c)) begin
            state_q <= S_REQ;
            dreq_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (DACK) begin
            state_q <= S_ACK;
            dreq_q  <= 1'b0;
          end else if (!EN) begin
            state_q <= S_IDLE;
            dreq_q  <= 1'b0;
          end
        end
        S_ACK: begin
          if (strobe_low_c) begin
            state_q <= S_XFER;
            db_oe_q <= dir_q;
            cap_q   <= DB_IN;
            if (dir_q) db_out_q <= head_c;
          end else if (!DACK) begin
            state_q <= S_IDLE;
          end
        end
        S_XFER: begin
          if (xfer_done_c) begin
            db_oe_q <= 1'b0;
            state_q <= DACK ? S_RECOVER : S_IDLE;
          end else if (!dir_q) begin
            cap_q <= DB_IN;
          end
        end
        S_RECOVER: begin
          if (!DACK) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_io_device.sv
// Randomized scoreboard bench for dma_io_device: a controller BFM, a host driver,
// an occupancy model and a monitor comparing bus/stream outputs against queues.
module tb_dma_io_device;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          EN, DIR, DREQ, DACK, IOR_N, IOW_N, EOP_N;
  logic [DW-1:0] DB_IN, DB_OUT;
  logic          DB_OE;
  logic          HIN_VALID;
  logic [DW-1:0] HIN_DATA;
  logic          HIN_READY, HOUT_VALID;
  logic [DW-1:0] HOUT_DATA;
  logic          HOUT_READY, TC, TC_CLR;

  dma_io_device #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .DIR(DIR), .DREQ(DREQ), .DACK(DACK),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT),
    .DB_OE(DB_OE), .HIN_VALID(HIN_VALID), .HIN_DATA(HIN_DATA), .HIN_READY(HIN_READY),
    .HOUT_VALID(HOUT_VALID), .HOUT_DATA(HOUT_DATA), .HOUT_READY(HOUT_READY),
    .TC(TC), .TC_CLR(TC_CLR)
  );

  always #5 CLK = ~CLK;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] sb_db[$];
  logic [DW-1:0] sb_hout[$];
  int            mcount = 0;
  bit            mdir   = 1'b1;
  bit            mtc    = 1'b0;
  bit            ev_pop = 1'b0;
  bit            ev_push = 1'b0;
  logic [DW-1:0] ev_data = '0;
  bit            m_hacc = 1'b0;
  bit            oe_prev = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no event want event within bound @%0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Occupancy model: FIFO count follows accepted pushes and pops only.
  initial forever begin
    int nc;
    @(posedge CLK);
    nc = mcount;
    m_hacc = 1'b0;
    if (RESET_N) begin
      if (HIN_VALID && mdir && mcount < int'(DEPTH)) begin
        nc++;
        sb_db.push_back(HIN_DATA);
        m_hacc = 1'b1;
      end
      if (HOUT_READY && !mdir && mcount > 0) nc--;
      if (ev_pop) nc--;
      if (ev_push) begin
        nc++;
        sb_hout.push_back(ev_data);
      end
      mcount = nc;
    end
    ev_pop  = 1'b0;
    ev_push = 1'b0;
  end

  // Monitor: compares DUT outputs against scoreboard queues and the model.
  initial forever begin
    logic [DW-1:0] e;
    @(negedge CLK);
    if (RESET_N) begin
      if (DB_OE) begin
        if (!oe_prev) begin
          if (sb_db.size() == 0) begin
            total++;
            bad++;
            $display("FAIL db_out_unexpected: got %0h want no transfer", DB_OUT);
          end else begin
            e = sb_db.pop_front();
            chk("db_out", DB_OUT, e);
            held = DB_OUT;
          end
        end else begin
          chk("db_out_hold", DB_OUT, held);
        end
      end
      if (HOUT_READY) begin
        chk("hout_valid", HOUT_VALID, (!mdir && mcount > 0));
        if (HOUT_VALID && sb_hout.size() != 0) begin
          e = sb_hout.pop_front();
          chk("hout_data", HOUT_DATA, e);
        end
      end
      if (HIN_VALID) chk("hin_ready", HIN_READY, (mdir && mcount < int'(DEPTH)));
    end
    oe_prev = DB_OE;
  end

  task automatic wait_dreq(input int lim, output int n, output bit ok);
    n = 0;
    while (DREQ !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    ok = (DREQ === 1'b1);
    if (!ok) fail("dreq_timeout");
  endtask

  task automatic host_push(input logic [DW-1:0] d);
    HIN_VALID = 1'b1;
    HIN_DATA  = d;
    tick();
    HIN_VALID = 1'b0;
  endtask

  task automatic set_dir(input bit d);
    EN = 1'b0;
    repeat (2) tick();
    DIR = d;
    repeat (2) tick();
    mdir = d;
  endtask

  // Controller BFM: one single-mode transfer, DREQ assumed high on entry.
  task automatic dma_xfer(input logic [DW-1:0] wd, input int n_low, input bit eop, input bit clr);
    DACK = 1'b1;
    tick();
    chk("dreq_drop_after_dack", DREQ, 1'b0);
    if (mdir) IOR_N = 1'b0;
    else      IOW_N = 1'b0;
    DB_IN  = (n_low > 1) ? DW'($urandom) : wd;
    EOP_N  = !eop;
    TC_CLR = clr;
    tick();
    EOP_N  = 1'b1;
    TC_CLR = 1'b0;
    if (eop) mtc = 1'b1;
    for (int i = 1; i < n_low; i++) begin
      DB_IN = (i == n_low - 1) ? wd : DW'($urandom);
      tick();
    end
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    DB_IN = DW'($urandom);
    if (mdir) ev_pop = 1'b1;
    else begin
      ev_push = 1'b1;
      ev_data = wd;
    end
    tick();
    chk("db_oe_after_strobe", DB_OE, 1'b0);
    DACK = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int            n;
    bit            ok;
    logic [DW-1:0] d;

    RESET_N = 1'b0; EN = 1'b0; DIR = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1;
    EOP_N = 1'b1; DB_IN = '0; HIN_VALID = 1'b0; HIN_DATA = '0; HOUT_READY = 1'b0; TC_CLR = 1'b0;
    repeat (2) tick();
    chk("rst_dreq", DREQ, 1'b0);
    chk("rst_db_oe", DB_OE, 1'b0);
    chk("rst_db_out", DB_OUT, 8'h00);
    chk("rst_tc", TC, 1'b0);
    chk("rst_hin_ready", HIN_READY, 1'b1);
    chk("rst_hout_valid", HOUT_VALID, 1'b0);
    RESET_N = 1'b1;
    tick();

    // Device to memory: two host bytes read out by the controller.
    set_dir(1'b1);
    EN = 1'b1;
    host_push(8'hA5);
    chk("dreq_not_yet", DREQ, 1'b0);
    host_push(8'h3C);
    chk("dreq_latency", DREQ, 1'b1);
    dma_xfer('0, 2, 1'b0, 1'b0);
    wait_dreq(10, n, ok);
    chk("rereq_latency", n, 1);
    if (ok) dma_xfer('0, 1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("empty_no_dreq", DREQ, 1'b0);

    // Memory to device: fill the FIFO from the bus, then drain via host.
    set_dir(1'b0);
    EN = 1'b1;
    wait_dreq(10, n, ok);
    if (ok) dma_xfer(8'h5A, 2, 1'b0, 1'b0);
    chk("hout_valid_first", HOUT_VALID, 1'b1);
    chk("hout_data_first", HOUT_DATA, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      wait_dreq(10, n, ok);
      if (ok) dma_xfer(DW'($urandom), $urandom_range(1, 3), 1'b0, 1'b0);
    end
    repeat (4) tick();
    chk("full_no_dreq", DREQ, 1'b0);
    chk("full_hin_ready", HIN_READY, 1'b0);
    EN = 1'b0;
    HOUT_READY = 1'b1;
    repeat (6) tick();
    HOUT_READY = 1'b0;
    chk("drain_sb_empty", sb_hout.size(), 0);

    // Terminal count: EOP on the 2nd of 3 bytes, TC_CLR in the same cycle.
    set_dir(1'b1);
    EN = 1'b1;
    for (int i = 0; i < 3; i++) host_push(DW'($urandom));
    wait_dreq(10, n, ok);
    if (ok) dma_xfer('0, 1, 1'b0, 1'b0);
    wait_dreq(10, n, ok);
    if (ok) dma_xfer('0, 2, 1'b1, 1'b1);
    chk("tc_set", TC, mtc);
    repeat (4) tick();
    chk("tc_blocks_dreq", DREQ, 1'b0);
    TC_CLR = 1'b1;
    tick();
    TC_CLR = 1'b0;
    mtc = 1'b0;
    chk("tc_clr", TC, mtc);
    wait_dreq(10, n, ok);
    if (ok) dma_xfer('0, 1, 1'b0, 1'b0);

    // Abort: DACK withdrawn in ACK without a strobe.
    host_push(DW'($urandom));
    wait_dreq(10, n, ok);
    DACK = 1'b1;
    tick();
    DACK = 1'b0;
    tick();
    chk("abort_dreq_low", DREQ, 1'b0);
    wait_dreq(10, n, ok);
    chk("abort_rereq_latency", n, 1);
    if (ok) dma_xfer('0, 1, 1'b0, 1'b0);

    // Concurrent host pushes and DMA pops through a full FIFO, 10 bytes total.
    for (int i = 0; i < 4; i++) host_push(DW'($urandom));
    chk("prefill_full", HIN_READY, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int w;
          repeat ($urandom_range(0, 2)) tick();
          HIN_VALID = 1'b1;
          HIN_DATA  = DW'($urandom);
          w = 0;
          do begin
            tick();
            w++;
          end while (!m_hacc && w < 200);
          HIN_VALID = 1'b0;
          if (!m_hacc) fail("hin_accept_timeout");
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          int wn;
          bit wok;
          wait_dreq(60, wn, wok);
          if (wok) dma_xfer('0, $urandom_range(1, 3), 1'b0, 1'b0);
        end
      end
    join
    chk("wrap_sb_empty", sb_db.size(), 0);

    // Reset in the middle of a read transfer.
    host_push(8'hC3);
    wait_dreq(10, n, ok);
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    chk("mid_db_oe", DB_OE, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_db_oe", DB_OE, 1'b0);
    chk("async_dreq", DREQ, 1'b0);
    DACK  = 1'b0;
    IOR_N = 1'b1;
    mcount = 0;
    sb_db.delete();
    sb_hout.delete();
    mdir = 1'b1;
    mtc  = 1'b0;
    tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    chk("post_rst_dreq", DREQ, 1'b0);
    chk("post_rst_tc", TC, mtc);
    chk("post_rst_hin_ready", HIN_READY, 1'b1);
    chk("post_rst_hout_valid", HOUT_VALID, 1'b0);
    d = 8'h77;
    host_push(d);
    wait_dreq(10, n, ok);
    if (ok) dma_xfer('0, 1, 1'b0, 1'b0);
    repeat (2) tick();
    chk("final_sb_db", sb_db.size(), 0);
    chk("final_sb_hout", sb_hout.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
